// File: rtl/rvfi_serializer_pkg.sv
// rvfi_serializer_pkg: buffered retire entry type and width helpers for the retire serializer
package rvfi_serializer_pkg;
  localparam int ENTRY_XLEN = 32;
  typedef struct packed {
    logic [63:0]           order;
    logic [ENTRY_XLEN-1:0] pc_rdata;
    logic [ENTRY_XLEN-1:0] pc_wdata;
  } entry_t;
  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction
  function automatic int lvl_w(input int depth);
    return $clog2(depth) + 1;
  endfunction
  function automatic int cnt_w(input int nret);
    return $clog2(nret + 1);
  endfunction
endpackage

// File: rtl/rvfi_serializer_compact.sv
// rvfi_serializer_compact: packs the valid retire channels into slots 0..k-1 in ascending channel order
module rvfi_serializer_compact
  import rvfi_serializer_pkg::*;
#(
  parameter int NRET = 2,
  parameter int XLEN = 32
) (
  input  logic [NRET-1:0]      valid,
  input  logic [64*NRET-1:0]   order,
  input  logic [XLEN*NRET-1:0] pc_rdata,
  input  logic [XLEN*NRET-1:0] pc_wdata,
  output logic [cnt_w(NRET)-1:0] k,
  output entry_t               ents [NRET]
);
  always_comb begin
    int cnt;
    cnt = 0;
    ents = '{default: '0};
    for (int i = 0; i < NRET; i++) begin
      if (valid[i]) begin
        for (int j = 0; j < NRET; j++) begin
          if (cnt == j) begin
            ents[j].order = order[64*i +: 64];
            ents[j].pc_rdata = ENTRY_XLEN'(pc_rdata[XLEN*i +: XLEN]);
            ents[j].pc_wdata = ENTRY_XLEN'(pc_wdata[XLEN*i +: XLEN]);
          end
        end
        cnt = cnt + 1;
      end
    end
    k = cnt_w(NRET)'(cnt);
  end
endmodule

// File: rtl/rvfi_retire_serializer.sv
// rvfi_retire_serializer: serializes multi-retire RVFI into one in-order channel; PC-chain check under RISCV_FORMAL_SERIALIZER_PCCHK_EN
module rvfi_retire_serializer
  import rvfi_serializer_pkg::*;
#(
  parameter int NRET  = 2,
  parameter int XLEN  = 32,
  parameter int DEPTH = 8
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [NRET-1:0]         rvfi_valid,
  input  logic [64*NRET-1:0]      rvfi_order,
  input  logic [XLEN*NRET-1:0]    rvfi_pc_rdata,
  input  logic [XLEN*NRET-1:0]    rvfi_pc_wdata,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [63:0]             out_order,
  output logic [XLEN-1:0]         out_pc_rdata,
  output logic [XLEN-1:0]         out_pc_wdata,
  output logic [lvl_w(DEPTH)-1:0] level,
  output logic                    overflow,
  output logic                    seq_err,
  output logic                    pc_err
);
  localparam int PW = ptr_w(DEPTH);
  localparam int LW = lvl_w(DEPTH);
  localparam int KW = cnt_w(NRET);
  logic [KW-1:0] k;
  entry_t        ents [NRET];
  entry_t        mem [DEPTH];
  entry_t        head;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          accept;
  logic          pop;
  logic          have_last;
  logic [63:0]   last_order;
  rvfi_serializer_compact #(.NRET(NRET), .XLEN(XLEN)) compact (
    .valid    (rvfi_valid),
    .order    (rvfi_order),
    .pc_rdata (rvfi_pc_rdata),
    .pc_wdata (rvfi_pc_wdata),
    .k        (k),
    .ents     (ents)
  );
  assign head = mem[rd_ptr];
  assign out_valid = level != '0;
  assign out_order = head.order;
  assign out_pc_rdata = XLEN'(head.pc_rdata);
  assign out_pc_wdata = XLEN'(head.pc_wdata);
  assign pop = out_valid && out_ready;
  // free space is judged on the pre-pop level, so a pop never makes room for this cycle's group
  assign accept = LW'(k) <= LW'(DEPTH) - level;
  always_ff @(posedge clock) begin
    for (int j = 0; j < NRET; j++)
      if (accept && KW'(j) < k) mem[wr_ptr + PW'(j)] <= ents[j];
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      overflow   <= 1'b0;
      seq_err    <= 1'b0;
      have_last  <= 1'b0;
      last_order <= '0;
    end else begin
      wr_ptr   <= accept ? wr_ptr + PW'(k) : wr_ptr;
      rd_ptr   <= rd_ptr + PW'(pop);
      level    <= level + (accept ? LW'(k) : LW'(0)) - LW'(pop);
      overflow <= overflow | ~accept;
      if (pop) begin
        seq_err    <= seq_err | (have_last && out_order != last_order + 64'd1);
        last_order <= out_order;
        have_last  <= 1'b1;
      end
    end
  end
`ifdef RISCV_FORMAL_SERIALIZER_PCCHK_EN
  logic [XLEN-1:0] last_pc_wdata;
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pc_err        <= 1'b0;
      last_pc_wdata <= '0;
    end else if (pop) begin
      pc_err        <= pc_err | (have_last && out_pc_rdata != last_pc_wdata);
      last_pc_wdata <= out_pc_wdata;
    end
  end
`else
  assign pc_err = 1'b0;
`endif
endmodule

// File: tb/tb_rvfi_retire_serializer.sv
// tb_rvfi_retire_serializer: scoreboard bench with a queue-based reference model of the serializer
module tb_rvfi_retire_serializer;
  localparam int NRET = 2;
  localparam int XLEN = 32;
  localparam int DEPTH = 8;
  typedef struct {
    logic [63:0]     order;
    logic [XLEN-1:0] rd;
    logic [XLEN-1:0] wd;
  } exp_t;
  logic clock = 1'b0;
  logic reset = 1'b0;
  logic [NRET-1:0] rvfi_valid = '0;
  logic [64*NRET-1:0] rvfi_order = '0;
  logic [XLEN*NRET-1:0] rvfi_pc_rdata = '0;
  logic [XLEN*NRET-1:0] rvfi_pc_wdata = '0;
  logic out_valid;
  logic out_ready = 1'b0;
  logic [63:0] out_order;
  logic [XLEN-1:0] out_pc_rdata;
  logic [XLEN-1:0] out_pc_wdata;
  logic [$clog2(DEPTH):0] level;
  logic overflow;
  logic seq_err;
  logic pc_err;
  always #5 clock = ~clock;
  rvfi_retire_serializer #(.NRET(NRET), .XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clock         (clock),
    .reset         (reset),
    .rvfi_valid    (rvfi_valid),
    .rvfi_order    (rvfi_order),
    .rvfi_pc_rdata (rvfi_pc_rdata),
    .rvfi_pc_wdata (rvfi_pc_wdata),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_order     (out_order),
    .out_pc_rdata  (out_pc_rdata),
    .out_pc_wdata  (out_pc_wdata),
    .level         (level),
    .overflow      (overflow),
    .seq_err       (seq_err),
    .pc_err        (pc_err)
  );
  int checks = 0;
  int failures = 0;
  exp_t exp_q[$];
  exp_t pend_q[$];
  logic pend_drop = 1'b0;
  logic exp_ovf = 1'b0;
  logic exp_seq = 1'b0;
  logic exp_pc = 1'b0;
  logic seq_pend = 1'b0;
  logic pc_pend = 1'b0;
  logic have_last = 1'b0;
  logic [63:0] last_order = '0;
  logic [XLEN-1:0] last_wd = '0;
  logic [63:0] next_order = '0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask
  task automatic clear_model();
    exp_q.delete();
    pend_q.delete();
    pend_drop = 1'b0;
    exp_ovf = 1'b0;
    exp_seq = 1'b0;
    exp_pc = 1'b0;
    seq_pend = 1'b0;
    pc_pend = 1'b0;
    have_last = 1'b0;
  endtask
  // one cycle: retire the group captured at this edge into the model, then offer the next group
  task automatic step(input logic [NRET-1:0] v, input logic [63:0] o0, input logic [63:0] o1, input logic rdy);
    exp_t grp[$];
    @(posedge clock);
    #1;
    while (pend_q.size() > 0) exp_q.push_back(pend_q.pop_front());
    if (pend_drop) exp_ovf = 1'b1;
    pend_drop = 1'b0;
    for (int i = 0; i < NRET; i++) begin
      exp_t e;
      e.order = (i == 0) ? o0 : o1;
      e.rd = $urandom;
      e.wd = $urandom;
      rvfi_order[64*i +: 64] = e.order;
      rvfi_pc_rdata[XLEN*i +: XLEN] = e.rd;
      rvfi_pc_wdata[XLEN*i +: XLEN] = e.wd;
      if (v[i]) grp.push_back(e);
    end
    if (grp.size() <= DEPTH - exp_q.size()) pend_q = grp;
    else pend_drop = 1'b1;
    rvfi_valid = v;
    out_ready = rdy;
  endtask
  task automatic astep(input logic [NRET-1:0] v, input logic rdy);
    logic [63:0] o0;
    logic [63:0] o1;
    o0 = '0;
    o1 = '0;
    if (v[0]) begin o0 = next_order; next_order++; end
    if (v[1]) begin o1 = next_order; next_order++; end
    step(v, o0, o1, rdy);
  endtask
  task automatic idle(input int n, input logic rdy);
    repeat (n) step('0, '0, '0, rdy);
  endtask
  task automatic do_reset();
    @(posedge clock);
    #1;
    reset = 1'b0;
    rvfi_valid = '0;
    out_ready = 1'b0;
    #1;
    chk("rst_level", 64'(level), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_overflow", 64'(overflow), 64'd0);
    chk("rst_seq_err", 64'(seq_err), 64'd0);
    chk("rst_pc_err", 64'(pc_err), 64'd0);
    clear_model();
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
  endtask
  // monitor: flags and occupancy every cycle, head contents whenever valid, scoreboard pop on handshake
  always @(negedge clock) begin
    if (reset) begin
      if (seq_pend) exp_seq = 1'b1;
      if (pc_pend) exp_pc = 1'b1;
      seq_pend = 1'b0;
      pc_pend = 1'b0;
      chk("level", 64'(level), 64'(exp_q.size()));
      chk("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
      chk("overflow", 64'(overflow), 64'(exp_ovf));
      chk("seq_err", 64'(seq_err), 64'(exp_seq));
      chk("pc_err", 64'(pc_err), 64'(exp_pc));
      if (out_valid && exp_q.size() > 0) begin
        chk("head_order", out_order, exp_q[0].order);
        chk("head_pc_rdata", 64'(out_pc_rdata), 64'(exp_q[0].rd));
        chk("head_pc_wdata", 64'(out_pc_wdata), 64'(exp_q[0].wd));
        if (out_ready) begin
          exp_t e;
          e = exp_q.pop_front();
          if (have_last && e.order != last_order + 64'd1) seq_pend = 1'b1;
`ifdef RISCV_FORMAL_SERIALIZER_PCCHK_EN
          if (have_last && e.rd != last_wd) pc_pend = 1'b1;
`endif
          last_order = e.order;
          last_wd = e.wd;
          have_last = 1'b1;
        end
      end
    end
  end
  int pvs[4] = '{30, 50, 70, 95};
  int prs[4] = '{90, 60, 80, 40};
  initial begin
    #2;
    chk("init_level", 64'(level), 64'd0);
    chk("init_out_valid", 64'(out_valid), 64'd0);
    chk("init_overflow", 64'(overflow), 64'd0);
    chk("init_seq_err", 64'(seq_err), 64'd0);
    chk("init_pc_err", 64'(pc_err), 64'd0);
    @(posedge clock);
    #1;
    reset = 1'b1;
    next_order = 0;
    for (int i = 0; i < 10; i++) astep(2'b01, 1'b1);
    idle(3, 1'b1);
    do_reset();
    step(2'b11, 64'd4, 64'd5, 1'b0);
    idle(2, 1'b0);
    idle(2, 1'b1);
    step(2'b10, 64'd0, 64'd7, 1'b0);
    idle(2, 1'b0);
    idle(2, 1'b1);
    do_reset();
    next_order = 100;
    repeat (3) astep(2'b11, 1'b0);
    astep(2'b01, 1'b0);
    astep(2'b11, 1'b0);
    idle(1, 1'b0);
    astep(2'b11, 1'b1);
    idle(10, 1'b1);
    do_reset();
    step(2'b01, 64'd10, 64'd0, 1'b1);
    step(2'b01, 64'd11, 64'd0, 1'b1);
    step(2'b01, 64'd13, 64'd0, 1'b1);
    idle(2, 1'b1);
    step(2'b11, 64'd14, 64'd15, 1'b0);
    for (int s = 0; s < 4; s++) begin
      do_reset();
      next_order = (s == 2) ? 64'hFFFF_FFFF_FFFF_FFF8 : {32'd0, $urandom};
      for (int c = 0; c < 150; c++) begin
        logic [NRET-1:0] v;
        for (int b = 0; b < NRET; b++) v[b] = $urandom_range(0, 99) < pvs[s];
        if ($urandom_range(0, 29) == 0) next_order += 2;
        astep(v, $urandom_range(0, 99) < prs[s]);
      end
      idle(12, 1'b1);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/rvfi_retire_serializer.md
# rvfi_retire_serializer

Buffers up to NRET retirements per cycle from the core's RVFI port and replays them as a single in-order channel with a valid/ready handshake. Sits between the DUT's RVFI outputs and single-channel formal checkers and bench monitors, such as the PC-forward and order checks. Also flags order gaps, buffer overflow and, optionally, PC-chain breaks.

## Interface
Parameters:
- NRET, 2: retire channels on the input side.
- XLEN, 32: PC width.
- DEPTH, 8: buffer entries; power of two, DEPTH >= NRET.

Ports:
- clock  in  1  sole clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- rvfi_valid  in  NRET  per-channel retire valid.
- rvfi_order  in  64*NRET  per-channel instruction order.
- rvfi_pc_rdata  in  XLEN*NRET  per-channel PC of the instruction.
- rvfi_pc_wdata  in  XLEN*NRET  per-channel next PC.
- out_valid  out  1  head entry available.
- out_ready  in  1  consumer accepts the head entry.
- out_order  out  64  head order.
- out_pc_rdata  out  XLEN  head pc_rdata.
- out_pc_wdata  out  XLEN  head pc_wdata.
- level  out  $clog2(DEPTH)+1  current entry count.
- overflow  out  1  sticky: a retire group was dropped.
- seq_err  out  1  sticky: popped order not equal to previous popped order + 1.
- pc_err  out  1  sticky PC-chain error; tied 0 when the feature is compiled out.

## Operation
- Push: each cycle, k = popcount(rvfi_valid). The valid channels are compacted in ascending channel index and written at wr_ptr..wr_ptr+k-1, modulo DEPTH.
- Admission is all-or-nothing. Free = DEPTH - level, sampled before this cycle's pop.
  - If k > free, the whole group is dropped and overflow sets.
  - Nothing is partially written.
- Pop: occurs when out_valid && out_ready; rd_ptr advances by 1.
- out_valid = (level != 0). out_* are driven combinationally from the entry at rd_ptr.
- Push and pop in the same cycle: level_next = level + k - pop. A pop does not create room for the same cycle's push.
- Pointers are $clog2(DEPTH) bits and wrap naturally. level is a separate counter; full means level == DEPTH, empty means level == 0.
- Sequence check:
  - A register last_order and a flag have_last, both cleared on reset.
  - On each pop, if have_last is set and out_order != last_order + 1 (64-bit wrap), seq_err sets.
  - Every pop then loads last_order and sets have_last.
- Sticky flags clear only on reset.
- Reset mid-operation discards all buffered entries immediately; no drain.

## Timing
- Reset values: out_valid 0, level 0, overflow 0, seq_err 0, pc_err 0. Pointers, have_last and last_order are 0. out_order/out_pc_* are don't-care while out_valid is 0.
- Latency: an entry pushed at edge N is visible on out_* after edge N. It can be popped in the cycle following the push.
- Throughput is 1 pop/cycle. Sustained input above 1 retire/cycle eventually overflows. Sizing is the integrator's responsibility.
- Flags assert on the edge after the offending push or pop.
- out_valid does not drop while the consumer stalls. Head data is stable until popped.

## Configuration
- RISCV_FORMAL_SERIALIZER_PCCHK_EN defined:
  - On each pop with have_last set, compare out_pc_rdata with the previous popped pc_wdata. A mismatch sets pc_err.
  - Adds a last_pc_wdata register (XLEN).
- Undefined: no last_pc_wdata register; pc_err is constant 0.

## Structure
- Package rvfi_serializer_pkg holds:
  - the entry struct typedef (order[63:0], pc_rdata, pc_wdata, parameterised by XLEN through a localparam);
  - the pointer and level width helper functions.
- Sub-module rvfi_serializer_compact: combinational. Maps rvfi_valid plus channel data to k and a compacted entry array (entry j = j-th set channel). The top level keeps the pointers, storage, counters and checks.

## Test plan
- Single-channel stream, orders 0..9, out_ready=1 → each pops one cycle after its push; out_order 0..9 in sequence; seq_err=0.
- NRET=2, both channels valid with orders 4 (ch0) and 5 (ch1), out_ready=0 → level=2; head order 4, then 5 after out_ready pulses.
- Only ch1 valid (order 7) → single entry written, compacted to slot wr_ptr; level +1.
- Fill to level 7 with out_ready=0, then push k=2 → group dropped, overflow=1, level stays 7. Same fill with a concurrent pop also drops the group.
- Pop orders 10, 11, 13 → seq_err sets on the edge after 13 is popped. Drive reset low mid-stream → level=0, out_valid=0, flags cleared asynchronously.
- With PCCHK_EN: pop entries with pc_wdata 0x104, then pc_rdata 0x108 → pc_err=1. With pc_rdata 0x104 → pc_err stays 0.
